watch_seg_scan: RTL and testbench

- Display-side consumer of the watch time interface.
- Takes four BCD digits (HH:MM), the 1 Hz second indicator and the 3-bit calibration state.
- Drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Blinks the digit under calibration and uses the decimal point of the hour-low digit as the seconds colon.

---
 rtl/watch_disp_pkg.sv | 30 +++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/watch_seg_scan.sv | 118 +++++++++++
 tb/tb_watch_seg_scan.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/watch_disp_pkg.sv
// Shared constants for the watch display path: segment codes, digit slots and
// calibration-state encodings.
package watch_disp_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] DIG_ML = 2'd0;
    localparam logic [1:0] DIG_MH = 2'd1;
    localparam logic [1:0] DIG_HL = 2'd2;
    localparam logic [1:0] DIG_HH = 2'd3;

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_CAL_ML = 3'd1;
    localparam logic [2:0] ST_CAL_MH = 3'd2;
    localparam logic [2:0] ST_CAL_HL = 3'd3;
    localparam logic [2:0] ST_CAL_HH = 3'd4;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
    import watch_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/watch_seg_scan.sv
// Four-digit multiplexed 7-segment driver for the watch: frame-held digits,
// calibration blink and a seconds colon on the hour-units decimal point.
module watch_seg_scan
    import watch_disp_pkg::*;
#(
    parameter logic [25:0] CLK_FRE  = 26'd50_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] hour_h_i,
    input  logic [3:0] hour_l_i,
    input  logic [3:0] minutes_h_i,
    input  logic [3:0] minutes_l_i,
    input  logic       second_led_i,
    input  logic [2:0] state_flag_i,
    output logic [3:0] seg_sel,
    output logic [7:0] seg_data
);

    localparam int unsigned SCAN_DIV   = 32'(CLK_FRE) / SCAN_HZ;
    localparam int unsigned BLINK_HALF = 32'(CLK_FRE) / (2 * BLINK_HZ);
    localparam int unsigned SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit_idx;
    logic [3:0]         sh_hh, sh_hl, sh_mh, sh_ml;
    logic [2:0]         state_q;
    logic               second_q;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_off;

    logic       tick;
    logic [3:0] cur_bcd;
    logic [6:0] cur_seg;
    logic       cal;
    logic       blank;
    logic       dp;
    logic [7:0] data_nxt;

    assign tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Select the shadow digit for the active slot and build its pattern
    always_comb begin
        cur_bcd = sh_ml;
        case (digit_idx)
            DIG_ML:  cur_bcd = sh_ml;
            DIG_MH:  cur_bcd = sh_mh;
            DIG_HL:  cur_bcd = sh_hl;
            DIG_HH:  cur_bcd = sh_hh;
            default: cur_bcd = sh_ml;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    always_comb begin
        cal   = (state_q >= ST_CAL_ML) && (state_q <= ST_CAL_HH);
        blank = cal && blink_off && (digit_idx == 2'(state_q - 3'd1));
        dp    = 1'b1;
        if (digit_idx == DIG_HL) begin
            dp = cal ? 1'b0 : ~second_q;
        end
        data_nxt = blank ? {1'b1, SEG_BLANK} : {dp, cur_seg};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scan_cnt  <= '0;
            digit_idx <= DIG_ML;
            sh_hh     <= 4'd0;
            sh_hl     <= 4'd0;
            sh_mh     <= 4'd0;
            sh_ml     <= 4'd0;
            state_q   <= ST_RUN;
            second_q  <= 1'b0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
            seg_sel   <= 4'hF;
            seg_data  <= 8'hFF;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + SCAN_W'(1);
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
                // Latch a whole frame at once so a changing time never tears
                if (digit_idx == DIG_HH) begin
                    sh_hh <= hour_h_i;
                    sh_hl <= hour_l_i;
                    sh_mh <= minutes_h_i;
                    sh_ml <= minutes_l_i;
                end
            end

            state_q  <= state_flag_i;
            second_q <= second_led_i;

            // A new calibration step always begins in the visible phase
            if (state_flag_i != state_q) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            seg_sel  <= ~(4'b0001 << digit_idx);
            seg_data <= data_nxt;
        end
    end

endmodule

// File: tb/tb_watch_seg_scan.sv
// Self-checking bench for watch_seg_scan: directed scenarios plus random input
// activity, compared every cycle against a history-based reference model.
module tb_watch_seg_scan;

    localparam int unsigned SDIV  = 4;
    localparam int unsigned BHALF = 10;
    localparam int unsigned HMAX  = 4096;

    logic       clk;
    logic       rstn;
    logic [3:0] hour_h_i, hour_l_i, minutes_h_i, minutes_l_i;
    logic       second_led_i;
    logic [2:0] state_flag_i;
    logic [3:0] seg_sel;
    logic [7:0] seg_data;

    watch_seg_scan #(
        .CLK_FRE  (26'd1000),
        .SCAN_HZ  (250),
        .BLINK_HZ (50)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .hour_h_i     (hour_h_i),
        .hour_l_i     (hour_l_i),
        .minutes_h_i  (minutes_h_i),
        .minutes_l_i  (minutes_l_i),
        .second_led_i (second_led_i),
        .state_flag_i (state_flag_i),
        .seg_sel      (seg_sel),
        .seg_data     (seg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int n = 0;

    // Input history per clock edge since the last reset edge (edge 0)
    logic [3:0] h_hh [HMAX];
    logic [3:0] h_hl [HMAX];
    logic [3:0] h_mh [HMAX];
    logic [3:0] h_ml [HMAX];
    logic       h_sec [HMAX];
    logic [2:0] h_flag [HMAX];

    function automatic logic [7:0] glyph(input logic [3:0] v);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return (v > 4'd9) ? 8'hBF : tbl[v];
    endfunction

    // Display state after edge k is a function of inputs seen up to edge k-1
    task automatic model(input int k, output logic [3:0] esel, output logic [7:0] edata);
        int p, slot, cap, chg, phase;
        logic [3:0] digs [4];
        logic [2:0] st;
        logic sec, cal;
        p    = k - 1;
        slot = (p / SDIV) % 4;
        digs = '{4'd0, 4'd0, 4'd0, 4'd0};
        if (p >= 16) begin
            cap  = (p / 16) * 16;
            digs = '{h_ml[cap], h_mh[cap], h_hl[cap], h_hh[cap]};
        end
        st  = h_flag[p];
        sec = h_sec[p];
        chg = 0;
        for (int e = p; e >= 1; e--) begin
            if (h_flag[e] != h_flag[e-1]) begin
                chg = e;
                break;
            end
        end
        phase = ((p - chg) / BHALF) % 2;
        cal   = (st >= 3'd1) && (st <= 3'd4);
        esel  = 4'hF;
        esel[slot] = 1'b0;
        edata = glyph(digs[slot]);
        if (slot == 2) edata[7] = cal ? 1'b0 : ~sec;
        if (cal && phase == 1 && slot == int'(st) - 1) edata = 8'hFF;
    endtask

    task automatic check(input string tag, input logic [3:0] esel, input logic [7:0] edata);
        vectors++;
        assert (seg_sel === esel) else begin
            miscompares++;
            $error("FAIL %s seg_sel edge %0d observed %h expected %h", tag, n, seg_sel, esel);
        end
        vectors++;
        assert (seg_data === edata) else begin
            miscompares++;
            $error("FAIL %s seg_data edge %0d observed %h expected %h", tag, n, seg_data, edata);
        end
    endtask

    task automatic step(input string tag);
        logic [3:0] esel;
        logic [7:0] edata;
        @(posedge clk);
        if (!rstn) begin
            n = 0;
            h_flag[0] = 3'd0;
            h_sec[0]  = 1'b0;
            #1;
            check(tag, 4'hF, 8'hFF);
        end else begin
            n++;
            if (n >= HMAX) begin
                miscompares++;
                $display("FAIL history overflow observed %0d expected <%0d", n, HMAX);
                $fatal(1, "history overflow");
            end
            h_hh[n] = hour_h_i;  h_hl[n] = hour_l_i;
            h_mh[n] = minutes_h_i; h_ml[n] = minutes_l_i;
            h_sec[n] = second_led_i; h_flag[n] = state_flag_i;
            #1;
            model(n, esel, edata);
            check(tag, esel, edata);
        end
    endtask

    task automatic run(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    task automatic set_time(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        hour_h_i = a; hour_l_i = b; minutes_h_i = c; minutes_l_i = d;
    endtask

    task automatic random_run(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(19, 0) == 0)
                set_time(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(39, 0) == 0) state_flag_i = 3'($urandom);
            if ($urandom_range(29, 0) == 0) second_led_i = ~second_led_i;
            step(tag);
        end
    endtask

    initial begin
        rstn = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4);
        second_led_i = 1'b0;
        state_flag_i = 3'd0;

        run("reset", 5);
        rstn = 1'b1;
        step("first_slot");
        vectors++;
        assert (seg_sel === 4'hE && seg_data === 8'hC0) else begin
            miscompares++;
            $error("FAIL post_reset observed %h/%h expected e/c0", seg_sel, seg_data);
        end

        run("time_1234", 40);
        second_led_i = 1'b1;
        run("colon_on", 40);
        state_flag_i = 3'd2;
        run("cal_min_h", 64);
        state_flag_i = 3'd3;
        run("cal_hour_l", 48);
        state_flag_i = 3'd0;
        while (dut.digit_idx != 2'd1) step("align");
        minutes_l_i = 4'd7;
        run("frame_hold", 36);
        hour_h_i = 4'hC;
        state_flag_i = 3'd6;
        for (int i = 0; i < 6; i++) begin
            second_led_i = ~second_led_i;
            run("state6_dash", 7);
        end
        state_flag_i = 3'd4;
        run("cal_hour_h", 44);
        state_flag_i = 3'd1;
        run("cal_min_l", 44);

        random_run("random_a", 1500);

        while (dut.digit_idx != 2'd2) step("align_rst");
        rstn = 1'b0;
        run("mid_reset", 2);
        rstn = 1'b1;
        random_run("random_b", 600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
